// File: rtl/ctrl_frame_capture.sv
// ctrl_frame_capture: captures control frames from the header/body FIFOs into a ring of RAM slots that picosoc reads over iomem
module ctrl_frame_capture #(
  parameter int HEADER_DWIDTH = 128,
  parameter int SLOT_WORDS_LOG2 = 4,
  parameter int DEPTH_LOG2 = 5,
  parameter logic [7:0] DATA_BASE = 8'h04,
  parameter logic [7:0] CFG_BASE = 8'h14
) (
  input  logic clk,
  input  logic arst_n,
  input  logic [HEADER_DWIDTH-1:0] h_fifo_dout,
  output logic h_fifo_rden,
  input  logic h_fifo_empty,
  input  logic [7:0] b_fifo_dout,
  output logic b_fifo_rden,
  input  logic b_fifo_empty,
  input  logic b_fifo_del,
  input  logic iomem_valid,
  output logic iomem_ready,
  input  logic [3:0] iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata
);
  localparam int HW = HEADER_DWIDTH / 32;
  localparam int HCW = HW > 1 ? $clog2(HW) : 1;
  localparam int PW = DEPTH_LOG2 + 1;
  localparam int WCW = SLOT_WORDS_LOG2 + 1;
  localparam int AW = DEPTH_LOG2 + SLOT_WORDS_LOG2;
  typedef enum logic [1:0] {IDLE, HDR, BODY, COMMIT} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count;
  logic [HCW-1:0] hcnt_q, hcnt_d;
  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic [1:0] lane_q, lane_d;
  logic [31:0] acc_q, acc_d, rdata_q, rdata_d, ram_q, mem_wd, nacc, cfg_rd;
  logic [15:0] len_q, len_d, drop_cnt_q, drop_cnt_d;
  logic drop_q, drop_d, drop_full_q, drop_full_d;
  logic ign_bpdu_q, ign_bpdu_d, ign_pause_q, ign_pause_d;
  logic pend_q, pend_d, ready_q, ready_d;
  logic mem_we, len_we, empty, full, cfg_hit, data_hit, start, cfg_wr, pop, drop_clr, slot_room;
  logic [31:0] mem [2**AW];
  logic [15:0] len_mem [2**DEPTH_LOG2];
  logic [31:0] hword [HW];
  logic [47:0] dst;
  logic unused_ok;
  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction
  assign unused_ok = ^{iomem_addr, iomem_wdata, iomem_wstrb};
  assign empty = wr_ptr_q == rd_ptr_q;
  assign full = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) && (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]);
  assign count = wr_ptr_q - rd_ptr_q;
  assign dst = h_fifo_dout[111:64];
  assign h_fifo_rden = state_q == COMMIT;
  assign b_fifo_rden = state_q == BODY && !b_fifo_empty;
  assign nacc = acc_q | ({24'h0, b_fifo_dout} << {lane_q, 3'b000});
  assign slot_room = !drop_q && !wcnt_q[WCW-1];
  assign cfg_hit = iomem_addr[31:24] == CFG_BASE;
  assign data_hit = iomem_addr[31:24] == DATA_BASE;
  assign start = iomem_valid && !ready_q && !pend_q && (cfg_hit || data_hit);
  assign cfg_wr = start && cfg_hit && |iomem_wstrb;
  assign pop = cfg_wr && iomem_addr[3:2] == 2'd0 && iomem_wstrb[3] && iomem_wdata[30] && !empty;
  assign drop_clr = cfg_wr && iomem_addr[3:2] == 2'd2;
  assign cfg_rd = iomem_addr[3:2] == 2'd0 ? {!empty, 1'b0, ign_bpdu_q, ign_pause_q, 28'(count)} :
                  iomem_addr[3:2] == 2'd1 ? {16'h0, len_mem[rd_ptr_q[PW-2:0]]} :
                  iomem_addr[3:2] == 2'd2 ? {16'h0, drop_cnt_q} : 32'h0;
  assign iomem_ready = ready_q;
  assign iomem_rdata = rdata_q;
  always_comb
    for (int i = 0; i < HW; i++)
      hword[i] = bswap(32'(h_fifo_dout >> (HEADER_DWIDTH - 32 * (i + 1))));
  always_comb begin
    state_d = state_q;
    hcnt_d = hcnt_q;
    wcnt_d = wcnt_q;
    lane_d = lane_q;
    acc_d = acc_q;
    len_d = len_q;
    drop_d = drop_q;
    drop_full_d = drop_full_q;
    mem_we = 1'b0;
    mem_wd = hword[hcnt_q];
    len_we = 1'b0;
    case (state_q)
      IDLE: if (!h_fifo_empty && h_fifo_dout[114]) begin
        state_d = HDR;
        drop_full_d = full;
        drop_d = full || (ign_bpdu_q && dst == 48'h0180C2000000) || (ign_pause_q && dst == 48'h0180C2000001);
        hcnt_d = '0;
        wcnt_d = '0;
        lane_d = '0;
        acc_d = '0;
        len_d = 16'(HEADER_DWIDTH / 8);
      end
      HDR: begin
        mem_we = slot_room;
        wcnt_d = wcnt_q + WCW'(!wcnt_q[WCW-1]);
        hcnt_d = hcnt_q + 1'b1;
        state_d = hcnt_q == HCW'(HW - 1) ? BODY : HDR;
      end
      BODY: if (!b_fifo_empty) begin
        lane_d = lane_q + 1'b1;
        len_d = len_q + 16'(len_q != 16'hFFFF);
        acc_d = lane_q == 2'd3 ? 32'h0 : nacc;
        mem_we = lane_q == 2'd3 && slot_room;
        mem_wd = nacc;
        wcnt_d = wcnt_q + WCW'(lane_q == 2'd3 && !wcnt_q[WCW-1]);
        state_d = b_fifo_del ? COMMIT : BODY;
      end
      default: begin
        mem_we = slot_room && lane_q != 2'd0;
        mem_wd = acc_q;
        len_we = !drop_q;
        state_d = IDLE;
      end
    endcase
    wr_ptr_d = wr_ptr_q + PW'(state_q == COMMIT && !drop_q);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    drop_cnt_d = drop_clr ? 16'h0 : drop_cnt_q + 16'(state_q == COMMIT && drop_full_q && drop_cnt_q != 16'hFFFF);
    ign_bpdu_d = cfg_wr && iomem_addr[3:2] == 2'd0 && iomem_wstrb[3] ? iomem_wdata[29] : ign_bpdu_q;
    ign_pause_d = cfg_wr && iomem_addr[3:2] == 2'd0 && iomem_wstrb[3] ? iomem_wdata[28] : ign_pause_q;
    pend_d = start && data_hit;
    ready_d = (start && cfg_hit) || pend_q;
    rdata_d = start && cfg_hit ? cfg_rd : pend_q ? ram_q : 32'h0;
  end
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) begin
      state_q <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      hcnt_q <= '0;
      wcnt_q <= '0;
      lane_q <= '0;
      acc_q <= '0;
      len_q <= '0;
      drop_q <= 1'b0;
      drop_full_q <= 1'b0;
      drop_cnt_q <= '0;
      ign_bpdu_q <= 1'b0;
      ign_pause_q <= 1'b0;
      pend_q <= 1'b0;
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      hcnt_q <= hcnt_d;
      wcnt_q <= wcnt_d;
      lane_q <= lane_d;
      acc_q <= acc_d;
      len_q <= len_d;
      drop_q <= drop_d;
      drop_full_q <= drop_full_d;
      drop_cnt_q <= drop_cnt_d;
      ign_bpdu_q <= ign_bpdu_d;
      ign_pause_q <= ign_pause_d;
      pend_q <= pend_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
    end
  always_ff @(posedge clk) begin
    if (mem_we) mem[{wr_ptr_q[PW-2:0], wcnt_q[WCW-2:0]}] <= mem_wd;
    if (len_we) len_mem[wr_ptr_q[PW-2:0]] <= len_q;
    ram_q <= mem[{rd_ptr_q[PW-2:0], iomem_addr[SLOT_WORDS_LOG2+1:2]}];
  end
endmodule

// File: tb/tb_ctrl_frame_capture.sv
// tb_ctrl_frame_capture: scoreboard bench driving FIFO models and iomem transactions against ctrl_frame_capture
module tb_ctrl_frame_capture;
  localparam logic [127:0] HDR = 128'hABC4_0180_C200_0000_8899_AABB_CCDD_EEFF;
  typedef struct {
    logic [31:0] exp;
    logic chk;
    string nm;
  } exp_t;
  logic clk = 1'b0;
  logic arst_n = 1'b0;
  logic [127:0] h_fifo_dout = '0;
  logic h_fifo_rden;
  logic h_fifo_empty = 1'b1;
  logic [7:0] b_fifo_dout = '0;
  logic b_fifo_rden;
  logic b_fifo_empty = 1'b1;
  logic b_fifo_del = 1'b0;
  logic iomem_valid = 1'b0;
  logic iomem_ready;
  logic [3:0] iomem_wstrb = '0;
  logic [31:0] iomem_addr = '0;
  logic [31:0] iomem_wdata = '0;
  logic [31:0] iomem_rdata;
  logic [127:0] hq [$];
  logic [8:0] bq [$];
  exp_t sb [$];
  int checks = 0;
  int errors = 0;
  int h_pops = 0;
  int b_pops = 0;
  logic h_pend = 1'b0;
  logic b_pend = 1'b0;
  logic stall_mode = 1'b0;
  logic tog = 1'b0;
  ctrl_frame_capture dut (
    .clk(clk), .arst_n(arst_n),
    .h_fifo_dout(h_fifo_dout), .h_fifo_rden(h_fifo_rden), .h_fifo_empty(h_fifo_empty),
    .b_fifo_dout(b_fifo_dout), .b_fifo_rden(b_fifo_rden), .b_fifo_empty(b_fifo_empty), .b_fifo_del(b_fifo_del),
    .iomem_valid(iomem_valid), .iomem_ready(iomem_ready), .iomem_wstrb(iomem_wstrb),
    .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata)
  );
  initial forever #5 clk = ~clk;
  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  task automatic expect_eq(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, got, want);
    end
  endtask
  // FIFO models: pops requested before a rising edge are applied at the following falling edge
  initial forever begin
    @(negedge clk);
    if (h_pend && hq.size() > 0) begin
      void'(hq.pop_front());
      h_pops++;
    end
    if (b_pend && bq.size() > 0) begin
      void'(bq.pop_front());
      b_pops++;
    end
    tog = !tog;
    h_fifo_empty = hq.size() == 0;
    h_fifo_dout = hq.size() > 0 ? hq[0] : '0;
    b_fifo_empty = bq.size() == 0 || (stall_mode && tog);
    b_fifo_dout = bq.size() > 0 ? bq[0][7:0] : 8'h0;
    b_fifo_del = bq.size() > 0 ? bq[0][8] : 1'b0;
    #1;
    h_pend = h_fifo_rden;
    b_pend = b_fifo_rden;
    if (stall_mode && b_fifo_empty && bq.size() > 0) expect_eq("stall_no_pop", 32'(b_fifo_rden), 32'h0);
  end
  initial begin : mon
    exp_t x;
    forever begin
      @(negedge clk);
      if (iomem_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ready rdata %h", iomem_rdata);
        end else begin
          x = sb.pop_front();
          if (x.chk) begin
            checks++;
            if (iomem_rdata !== x.exp) begin
              errors++;
              $display("FAIL %s rdata %h want %h", x.nm, iomem_rdata, x.exp);
            end
          end
        end
      end
    end
  end
  task automatic bus(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d, input int lat,
                     input logic chk, input logic [31:0] e, input string nm);
    int n = 0;
    sb.push_back('{exp: e, chk: chk, nm: nm});
    iomem_addr = a;
    iomem_wstrb = s;
    iomem_wdata = d;
    iomem_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!iomem_ready && n < 20);
    iomem_valid = 1'b0;
    iomem_wstrb = 4'h0;
    checks++;
    if (n != lat || !iomem_ready) begin
      errors++;
      $display("FAIL %s latency %0d want %0d", nm, n, lat);
      if (!iomem_ready) void'(sb.pop_back());
    end
    @(negedge clk);
  endtask
  task automatic cfg_rd(input int r, input logic [31:0] e, input string nm);
    bus(32'h1400_0000 | 32'(r * 4), 4'h0, 32'h0, 1, 1'b1, e, nm);
  endtask
  task automatic cfg_wr(input int r, input logic [31:0] d, input string nm);
    bus(32'h1400_0000 | 32'(r * 4), 4'hF, d, 1, 1'b0, 32'h0, nm);
  endtask
  task automatic dat_rd(input int w, input logic [31:0] e, input string nm);
    bus(32'h0400_0000 | 32'(w * 4), 4'h0, 32'h0, 2, 1'b1, e, nm);
  endtask
  task automatic push_frame(input int n, input int base);
    hq.push_back(HDR);
    for (int i = 0; i < n; i++) bq.push_back({i == n - 1, 8'(base + i)});
  endtask
  task automatic wait_pops(input int target, input string nm);
    int n = 0;
    while (h_pops < target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    expect_eq(nm, 32'(h_pops), 32'(target));
    repeat (2) @(negedge clk);
  endtask
  task automatic check_reset_outputs(input string nm);
    expect_eq({nm, "_h_rden"}, 32'(h_fifo_rden), 32'h0);
    expect_eq({nm, "_b_rden"}, 32'(b_fifo_rden), 32'h0);
    expect_eq({nm, "_ready"}, 32'(iomem_ready), 32'h0);
    expect_eq({nm, "_rdata"}, iomem_rdata, 32'h0);
  endtask
  initial begin
    int hp, bp, n;
    repeat (3) @(negedge clk);
    #2;
    check_reset_outputs("por");
    @(negedge clk);
    arst_n = 1'b1;
    cfg_rd(0, 32'h0000_0000, "ctrl_after_reset");
    cfg_rd(2, 32'h0000_0000, "drop_after_reset");
    // 60-byte BPDU, no filter
    hp = h_pops;
    bp = b_pops;
    push_frame(60, 0);
    wait_pops(hp + 1, "bpdu_commit");
    expect_eq("bpdu_body_pops", 32'(b_pops - bp), 32'd60);
    cfg_rd(0, 32'h8000_0001, "bpdu_ctrl");
    cfg_rd(1, 32'd76, "bpdu_len");
    dat_rd(0, 32'h8001_C4AB, "bpdu_w0");
    dat_rd(1, 32'h0000_00C2, "bpdu_w1");
    dat_rd(3, 32'hFFEE_DDCC, "bpdu_w3");
    dat_rd(4, 32'h0302_0100, "bpdu_w4");
    dat_rd(15, 32'h2F2E_2D2C, "bpdu_w15");
    cfg_wr(0, 32'h4000_0000, "pop_bpdu");
    cfg_rd(0, 32'h0000_0000, "ctrl_after_pop");
    // same BPDU filtered
    cfg_wr(0, 32'h2000_0000, "set_ign_bpdu");
    hp = h_pops;
    bp = b_pops;
    push_frame(60, 0);
    wait_pops(hp + 1, "filt_hpop_once");
    expect_eq("filt_body_pops", 32'(b_pops - bp), 32'd60);
    expect_eq("filt_bq_drained", 32'(bq.size()), 32'h0);
    cfg_rd(0, 32'h2000_0000, "filt_ctrl");
    cfg_rd(2, 32'h0000_0000, "filt_drop");
    cfg_wr(0, 32'h0000_0000, "clr_ign");
    // 33 frames, no pops
    hp = h_pops;
    for (int k = 0; k < 33; k++) push_frame(4, k * 8);
    wait_pops(hp + 33, "full_commits");
    expect_eq("full_bq_drained", 32'(bq.size()), 32'h0);
    cfg_rd(0, 32'h8000_0020, "full_ctrl");
    cfg_rd(2, 32'h0000_0001, "full_drop");
    cfg_rd(1, 32'd20, "full_len");
    dat_rd(4, 32'h0302_0100, "full_head_w4");
    cfg_wr(0, 32'h4000_0000, "pop_first");
    dat_rd(4, 32'h0B0A_0908, "second_w4");
    cfg_rd(0, 32'h8000_001F, "ctrl_31");
    for (int k = 0; k < 31; k++) cfg_wr(0, 32'h4000_0000, "pop_rest");
    cfg_rd(0, 32'h0000_0000, "ctrl_drained");
    cfg_wr(0, 32'h4000_0000, "pop_empty");
    cfg_rd(0, 32'h0000_0000, "ctrl_extra_pop");
    cfg_rd(2, 32'h0000_0001, "drop_kept");
    cfg_wr(2, 32'h0000_0000, "clr_drop");
    cfg_rd(2, 32'h0000_0000, "drop_cleared");
    // 5-byte body with an intermittently empty body FIFO
    stall_mode = 1'b1;
    hp = h_pops;
    bp = b_pops;
    push_frame(5, 8'hA1);
    wait_pops(hp + 1, "stall_commit");
    stall_mode = 1'b0;
    expect_eq("stall_body_pops", 32'(b_pops - bp), 32'd5);
    cfg_rd(0, 32'h8000_0001, "stall_ctrl");
    cfg_rd(1, 32'd21, "stall_len");
    dat_rd(0, 32'h8001_C4AB, "stall_w0");
    dat_rd(4, 32'hA4A3_A2A1, "stall_w4");
    dat_rd(5, 32'h0000_00A5, "stall_w5_pad");
    cfg_wr(0, 32'h4000_0000, "pop_stall");
    // reset while in BODY
    bp = b_pops;
    push_frame(40, 0);
    n = 0;
    while (b_pops < bp + 10 && n < 200) begin
      @(negedge clk);
      n++;
    end
    expect_eq("midbody_reached", 32'(b_pops >= bp + 10), 32'h1);
    #2;
    arst_n = 1'b0;
    hq.delete();
    bq.delete();
    h_pend = 1'b0;
    b_pend = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    cfg_rd(0, 32'h0000_0000, "ctrl_after_midrst");
    hp = h_pops;
    push_frame(4, 8'h55);
    wait_pops(hp + 1, "fresh_commit");
    cfg_rd(0, 32'h8000_0001, "fresh_ctrl");
    cfg_rd(1, 32'd20, "fresh_len");
    dat_rd(0, 32'h8001_C4AB, "fresh_w0");
    dat_rd(4, 32'h5857_5655, "fresh_w4");
    cfg_rd(2, 32'h0000_0000, "fresh_drop");
    repeat (3) @(negedge clk);
    expect_eq("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
